// File: rtl/test_sequencer_pkg.sv
// Shared types for the test sequencer: state encoding and state helpers.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4,
        ST_TOUT  = 3'd5
    } state_t;

    // A new run may only be launched from idle or from a finished run.
    function automatic logic start_allowed(input state_t s);
        return (s == ST_IDLE) || (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TOUT);
    endfunction

endpackage

// File: rtl/test_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; next_count exposes the value
// the counter takes on the coming edge so callers can act in the same cycle.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] next_count
);

    // Clear wins over enable; an enabled counter sticks at all-ones.
    always_comb begin
        next_count = count;
        if (clr) begin
            next_count = '0;
        end else if (en && (count != {W{1'b1}})) begin
            next_count = count + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        count <= next_count;
    end

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: resets a core, runs it, detects a halt via a stable PC and
// grades the LEDR result, or times out.
// Optional feature macro: TEST_SEQUENCER_WATCH_EN adds a PC watchpoint that
// records the RUN cycle at which a given PC is first retired.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start, core held in reset
// ST_RESET | core reset asserted for RST_CYCLES cycles
// ST_RUN   | core running, counting cycles/retires, watching for halt
// ST_PASS  | halted with expected LEDR
// ST_FAIL  | halted with wrong LEDR
// ST_TOUT  | no halt within TIMEOUT_CYCLES
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 75,
    parameter int unsigned HALT_CYCLES    = 8,
    parameter int unsigned PC_W           = 32,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             insn_vld_i,
    input  logic [31:0]      ledr_i,
    input  logic [31:0]      expect_ledr_i,
    input  logic [31:0]      sw_i,
    output logic [31:0]      io_sw_o,
    output logic             core_rst_no,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [2:0]       state_o
`ifdef TEST_SEQUENCER_WATCH_EN
    ,
    input  logic [PC_W-1:0]  watch_pc_i,
    output logic             watch_hit_o,
    output logic [CNT_W-1:0] watch_cyc_o
`endif
);

    localparam int unsigned RST_W    = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned RST_LOAD = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;

    state_t            state;
    logic [RST_W-1:0]  rst_cnt;
    logic [PC_W-1:0]   pc_q;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [CNT_W-1:0]  retire_nxt;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  stable_nxt;

    logic run;
    logic start_acc;
    logic cnt_clr;
    logic first_run;
    logic pc_eq;
    logic stable_clr;
    logic halt;
    logic tout;
    logic ledr_match;

    assign state_o    = state;
    assign run        = (state == ST_RUN);
    assign start_acc  = start_i && start_allowed(state);
    assign cnt_clr    = rst_i || start_acc;
    // The cycle counter is still zero during the first RUN cycle; it never
    // returns to zero inside a run because it saturates instead of wrapping.
    assign first_run  = (cycle_cnt_o == '0);
    assign pc_eq      = (pc_i == pc_q);
    assign stable_clr = cnt_clr || (run && (first_run || !pc_eq));
    assign halt       = run && (32'(stable_nxt) == 32'(HALT_CYCLES));
    assign tout       = run && (32'(cycle_nxt) == 32'(TIMEOUT_CYCLES));
    assign ledr_match = (ledr_i == expect_ledr_i);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk        (clk_i),
        .clr        (cnt_clr),
        .en         (run),
        .count      (cycle_cnt_o),
        .next_count (cycle_nxt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk        (clk_i),
        .clr        (cnt_clr),
        .en         (run && insn_vld_i),
        .count      (retire_cnt_o),
        .next_count (retire_nxt)
    );

    sat_counter #(.W(CNT_W)) u_stable_cnt (
        .clk        (clk_i),
        .clr        (stable_clr),
        .en         (run && pc_eq && !first_run),
        .count      (stable_cnt),
        .next_count (stable_nxt)
    );

    // Sequencer FSM with registered status outputs; halt takes priority over timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            pc_q        <= '0;
            core_rst_no <= 1'b0;
            io_sw_o     <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_PASS, ST_FAIL, ST_TOUT: begin
                    if (start_i) begin
                        state     <= ST_RESET;
                        rst_cnt   <= RST_W'(RST_LOAD);
                        io_sw_o   <= sw_i;
                        done_o    <= 1'b0;
                        pass_o    <= 1'b0;
                        timeout_o <= 1'b0;
                    end
                end
                ST_RESET: begin
                    io_sw_o <= sw_i;
                    if (rst_cnt == '0) begin
                        state       <= ST_RUN;
                        core_rst_no <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RST_W'(1);
                    end
                end
                ST_RUN: begin
                    pc_q    <= pc_i;
                    io_sw_o <= sw_i;
                    if (halt) begin
                        state       <= ledr_match ? ST_PASS : ST_FAIL;
                        pass_o      <= ledr_match;
                        done_o      <= 1'b1;
                        core_rst_no <= 1'b0;
                        io_sw_o     <= '0;
                    end else if (tout) begin
                        state       <= ST_TOUT;
                        timeout_o   <= 1'b1;
                        done_o      <= 1'b1;
                        core_rst_no <= 1'b0;
                        io_sw_o     <= '0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    core_rst_no <= 1'b0;
                    io_sw_o     <= '0;
                    done_o      <= 1'b0;
                    pass_o      <= 1'b0;
                    timeout_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TEST_SEQUENCER_WATCH_EN
    // Sticky watchpoint: records the cycle count reached by the first matching retire.
    always_ff @(posedge clk_i) begin
        if (cnt_clr) begin
            watch_hit_o <= 1'b0;
            watch_cyc_o <= '0;
        end else if (run && !watch_hit_o && insn_vld_i && (pc_i == watch_pc_i)) begin
            watch_hit_o <= 1'b1;
            watch_cyc_o <= cycle_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: directed scenarios plus random PC
// profiles graded against a window-based reference model.
// Honours TEST_SEQUENCER_WATCH_EN to exercise the watchpoint ports.
module tb_test_sequencer;
    import test_sequencer_pkg::*;

    localparam int HALT = 8;
    localparam int TOUT = 75;
    localparam int MAXC = 65535;
    localparam int NPC  = 201;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rst4 = 1'b1;
    logic        start_i = 1'b0;
    logic        start4 = 1'b0;
    logic [31:0] pc_i = '0;
    logic        insn_vld_i = 1'b0;
    logic [31:0] ledr_i = '0;
    logic [31:0] expect_ledr_i = '0;
    logic [31:0] sw_i = '0;
    logic [31:0] io_sw_o, io_sw4;
    logic        core_rst_no, core_rst4;
    logic        done_o, pass_o, timeout_o, done4, pass4, timeout4;
    logic [15:0] cycle_cnt_o, retire_cnt_o;
    logic [3:0]  cycle4, retire4;
    logic [2:0]  state_o, state4;
`ifdef TEST_SEQUENCER_WATCH_EN
    logic [31:0] watch_pc_i = '0;
    logic        watch_hit_o, watch_hit4;
    logic [15:0] watch_cyc_o;
    logic [3:0]  watch_cyc4;
`endif

    logic [31:0] pcs [NPC];
    logic        vlds [NPC];

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    test_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
        .insn_vld_i(insn_vld_i), .ledr_i(ledr_i), .expect_ledr_i(expect_ledr_i),
        .sw_i(sw_i), .io_sw_o(io_sw_o), .core_rst_no(core_rst_no),
        .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o), .state_o(state_o)
`ifdef TEST_SEQUENCER_WATCH_EN
        , .watch_pc_i(watch_pc_i), .watch_hit_o(watch_hit_o), .watch_cyc_o(watch_cyc_o)
`endif
    );

    test_sequencer #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst4), .start_i(start4), .pc_i(pc_i),
        .insn_vld_i(insn_vld_i), .ledr_i(ledr_i), .expect_ledr_i(expect_ledr_i),
        .sw_i(sw_i), .io_sw_o(io_sw4), .core_rst_no(core_rst4),
        .done_o(done4), .pass_o(pass4), .timeout_o(timeout4),
        .cycle_cnt_o(cycle4), .retire_cnt_o(retire4), .state_o(state4)
`ifdef TEST_SEQUENCER_WATCH_EN
        , .watch_pc_i(watch_pc_i), .watch_hit_o(watch_hit4), .watch_cyc_o(watch_cyc4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, state_o, ST_IDLE);
        chk({tag, "_core_rst"}, core_rst_no, 0);
        chk({tag, "_io_sw"}, io_sw_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_pass"}, pass_o, 0);
        chk({tag, "_tout"}, timeout_o, 0);
        chk({tag, "_cycle"}, cycle_cnt_o, 0);
        chk({tag, "_retire"}, retire_cnt_o, 0);
    endtask

    // Halt at RUN cycle k when the PCs of cycles k-HALT..k are all equal
    // (HALT consecutive repeats, never counting the first RUN cycle);
    // otherwise the run ends by timeout at cycle TOUT.
    function automatic void model(output int k_end, output bit halted);
        bit same;
        halted = 1'b0;
        k_end  = TOUT;
        for (int k = HALT + 1; k <= TOUT; k++) begin
            if (!halted) begin
                same = 1'b1;
                for (int j = k - HALT; j < k; j++)
                    if (pcs[j] != pcs[k]) same = 1'b0;
                if (same) begin
                    halted = 1'b1;
                    k_end  = k;
                end
            end
        end
    endfunction

    task automatic do_run(input logic [31:0] led, input logic [31:0] exp_led, input bit use4);
        int k_end, rc, k, bad, retires;
        bit halted;
        state_t exp_state;
        logic [31:0] sw;
`ifdef TEST_SEQUENCER_WATCH_EN
        int wk;
`endif
        model(k_end, halted);
        retires = 0;
        for (int i = 1; i <= k_end; i++) retires += int'(vlds[i]);
        if (!halted)          exp_state = ST_TOUT;
        else if (led == exp_led) exp_state = ST_PASS;
        else                  exp_state = ST_FAIL;
        sw = $urandom;
        ledr_i = led; expect_ledr_i = exp_led; sw_i = sw;
        @(negedge clk_i);
        start_i = 1'b1; start4 = use4;
        @(negedge clk_i);
        start_i = 1'b0; start4 = 1'b0;
        chk("start_state", state_o, ST_RESET);
        chk("start_cnt_clr", {cycle_cnt_o, retire_cnt_o}, 0);
        rc = 0; bad = 0;
        while (state_o == ST_RESET && rc < 20) begin
            rc++;
            if (core_rst_no !== 1'b0 || io_sw_o !== sw) bad++;
            @(negedge clk_i);
        end
        chk("reset_len", rc, 4);
        k = 0;
        while (state_o == ST_RUN && k < NPC - 1) begin
            k++;
            if (core_rst_no !== 1'b1 || io_sw_o !== sw || done_o !== 1'b0) bad++;
            pc_i = pcs[k]; insn_vld_i = vlds[k];
            @(negedge clk_i);
        end
        insn_vld_i = 1'b0;
        chk("run_sigs_bad", bad, 0);
        chk("run_len", k, k_end);
        chk("end_state", state_o, exp_state);
        chk("end_cycle", cycle_cnt_o, (k_end > MAXC) ? MAXC : k_end);
        chk("end_retire", retire_cnt_o, retires);
        chk("end_flags", {done_o, pass_o, timeout_o, core_rst_no},
            {1'b1, exp_state == ST_PASS, exp_state == ST_TOUT, 1'b0});
        chk("end_io_sw", io_sw_o, 0);
`ifdef TEST_SEQUENCER_WATCH_EN
        wk = 0;
        for (int i = 1; i <= k_end; i++)
            if (wk == 0 && vlds[i] && pcs[i] == watch_pc_i) wk = i;
        chk("watch_hit", watch_hit_o, wk != 0);
        chk("watch_cyc", watch_cyc_o, wk);
`endif
        // Counters must hold in the terminal state.
        @(negedge clk_i);
        chk("hold_cycle", cycle_cnt_o, k_end);
    endtask

    task automatic fill_ramp(input int stop_k);
        for (int k = 0; k < NPC; k++) begin
            pcs[k]  = 32'(4 * ((k < stop_k) ? k : stop_k));
            vlds[k] = 1'(k % 3 != 2);
        end
    endtask

    initial begin
        int rc, seg, left;
        logic [31:0] val, led;
        repeat (3) @(negedge clk_i);
        check_reset_vals("por");
        rst_i = 1'b0; rst4 = 1'b0;

        // Ramp by 4 for 20 cycles then park at 0x50: halt at cycle 28.
        fill_ramp(20);
        do_run(32'hA5, 32'hA5, 1'b0);
        chk("pass_cycle28", cycle_cnt_o, 28);
        chk("pass_flag", pass_o, 1);
        do_run(32'h00, 32'hA5, 1'b0);
        chk("fail_state", state_o, ST_FAIL);

        // Never stable: timeout.
        fill_ramp(NPC);
        do_run(32'h1, 32'h1, 1'b0);
        chk("tout_cycle75", cycle_cnt_o, 75);
        chk("tout_flag", timeout_o, 1);

        // Halt lands exactly on cycle 75: halt must win.
        fill_ramp(67);
        do_run(32'h3, 32'h3, 1'b0);
        chk("tie_state", state_o, ST_PASS);
        chk("tie_cycle", cycle_cnt_o, 75);

        // Narrow counters saturate at 15.
        fill_ramp(20);
        for (int k = 0; k < NPC; k++) vlds[k] = 1'b1;
        do_run(32'h7, 32'h7, 1'b1);
        chk("sat_retire4", retire4, 15);
        chk("sat_cycle4", cycle4, 15);
        chk("sat_state4", state4, ST_PASS);

        // Start from PASS clears, start in RUN is ignored, reset aborts a run.
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        chk("restart_state", state_o, ST_RESET);
        chk("restart_clr", {cycle_cnt_o, retire_cnt_o, done_o, pass_o}, 0);
`ifdef TEST_SEQUENCER_WATCH_EN
        chk("restart_watch", watch_hit_o, 0);
`endif
        rc = 0;
        while (state_o != ST_RUN && rc < 20) begin rc++; @(negedge clk_i); end
        chk("mid_in_run", state_o, ST_RUN);
        for (int i = 1; i <= 3; i++) begin
            pc_i = 32'h1000 + 32'(4 * i); insn_vld_i = 1'b1;
            @(negedge clk_i);
        end
        start_i = 1'b1; pc_i = 32'h2000;
        @(negedge clk_i);
        start_i = 1'b0; pc_i = 32'h3000;
        chk("start_ignored", state_o, ST_RUN);
        chk("start_ignored_cnt", cycle_cnt_o, 4);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_vals("midrst");
        rst_i = 1'b0; insn_vld_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_stay_idle", state_o, ST_IDLE);

`ifdef TEST_SEQUENCER_WATCH_EN
        // 0x10 first retired at cycle 5, hit again from cycle 9 onward.
        for (int k = 0; k < NPC; k++) begin
            pcs[k]  = (k <= 8) ? 32'(4 * (k - 1)) : 32'h10;
            vlds[k] = 1'b1;
        end
        watch_pc_i = 32'h10;
        do_run(32'h5, 32'h5, 1'b0);
        chk("watch_dir_hit", watch_hit_o, 1);
        chk("watch_dir_cyc", watch_cyc_o, 5);
`endif

        // Random segmented PC profiles.
        for (int r = 0; r < 30; r++) begin
            val = $urandom & 32'hFFFF_FFFC;
            left = 0;
            for (int k = 0; k < NPC; k++) begin
                if (left == 0) begin
                    seg = $urandom_range(1, HALT + 1);
                    left = seg;
                    val = val + 32'(4 * $urandom_range(1, 100));
                end
                pcs[k]  = val;
                vlds[k] = 1'($urandom_range(0, 1));
                left--;
            end
`ifdef TEST_SEQUENCER_WATCH_EN
            watch_pc_i = pcs[$urandom_range(1, 20)];
`endif
            led = $urandom;
            do_run(led, ($urandom_range(0, 1) == 1) ? led : (led ^ (32'h1 << $urandom_range(0, 31))), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
